pte_mem_port: RTL and testbench
===============================

Name: pte_mem_port

Overview:
- Memory-side responder for the MMU page-walk port.
- Accepts single-word PTE read requests (L1/L0 fetch) and PTE write-back requests (A/D update) from the MMU.
- Sequences each request onto the shared DRAM word interface.
- Returns read data and a busy flag in the form the MMU page-walk FSM samples: it waits for !busy, then latches data.

Parameters:
- TIMEOUT_CYCLES, 1023, max cycles to wait for DRAM ack before abort (1..65535)
- ADDR_WIDTH, 32, physical address width of PTE and DRAM addresses

Ports:
- CLK  in  1  clock
- RST_X  in  1  reset; one clock, synchronous, active-low
- w_pte_req  in  1  one-cycle request strobe from MMU
- w_pte_we  in  1  1 = PTE write-back, 0 = PTE read
- w_pte_addr  in  ADDR_WIDTH  PTE physical address, word aligned
- w_pte_wdata  in  32  write-back data
- w_tlb_flush  in  1  sfence.vma / satp change
- w_pte_busy  out  1  request in flight; MMU must not sample w_pte_odata
- w_pte_odata  out  32  last read PTE, stable while busy=0
- w_pte_err  out  1  one-cycle pulse: misaligned request or timeout
- w_dram_req  out  1  DRAM request, held until ack
- w_dram_we  out  1  DRAM write enable, valid with req
- w_dram_addr  out  ADDR_WIDTH  DRAM word address, valid with req
- w_dram_wdata  out  32  DRAM write data, valid with req
- w_dram_ack  in  1  one-cycle completion pulse from DRAM
- w_dram_rdata  in  32  read data, valid with ack

Behaviour:
- Reset (RST_X=0 at posedge): state=IDLE; all outputs 0, including w_pte_busy, w_pte_odata and w_dram_req; timeout counter 0; last-hit entry invalid.
- States: IDLE, REQ, DONE.
- IDLE:
  - w_pte_req=1 with w_pte_addr[1:0]!=0 → reject: w_pte_err pulses next cycle, busy stays 0, no DRAM access.
  - Aligned request → latch we/addr/wdata; next cycle w_pte_busy=1, w_dram_req=1, state=REQ, counter cleared.
- REQ:
  - DRAM outputs held stable; counter increments each cycle.
  - w_dram_ack=1 → drop w_dram_req; on read, load w_pte_odata from w_dram_rdata; state=DONE.
  - Ack is honoured in the first REQ cycle (zero-wait DRAM).
  - Counter reaches TIMEOUT_CYCLES with no ack → drop req; w_pte_odata=0 on read; w_pte_err pulses; state=DONE.
- DONE: w_pte_busy=0 and state=IDLE at the next edge. Net: busy falls exactly one cycle after ack.
- Read latency: ack at cycle k → busy=0 and odata valid at cycle k+1.
- Write: w_pte_odata unchanged; busy drops the same way.
- w_pte_req while state!=IDLE is ignored (no queueing), and w_pte_err pulses.
- w_dram_ack in IDLE or DONE is ignored. This covers a stale ack after reset or after a timeout.
- Reset mid-REQ: req dropped immediately, state returns to IDLE, and a pending ack is ignored.
- w_tlb_flush has no effect on an in-flight request.
- Width rules: w_dram_addr = latched address verbatim; counter is 16 bits and saturates.

Optional Feature:
- Macro PTE_PORT_LASTHIT_EN.
- Defined:
  - One-entry {valid, addr, data} register holding the last completed read, or the last acked write (address plus wdata).
  - Aligned read in IDLE whose address matches a valid entry: no DRAM request; busy pulses 1 for exactly one cycle, then odata=entry data.
  - Write to a matching address updates the entry on ack.
  - w_tlb_flush, reset or timeout invalidates the entry; a flush coinciding with an ack wins, leaving the entry invalid.
- Undefined: entry absent; every read goes to DRAM.

Test Plan:
- Read 0x8000_1004, DRAM acks after 3 cycles with 0x2000_00CF → w_dram_req high 3 cycles with addr 0x8000_1004, we=0; busy falls one cycle after ack; odata=0x2000_00CF.
- Write 0x8000_1004 data 0x2000_00CF, zero-wait ack → w_dram_we=1, wdata matches; busy high exactly 2 cycles; odata unchanged.
- Read 0x8000_1006 → err pulse next cycle; w_dram_req stays 0; busy stays 0.
- Read with no ack, TIMEOUT_CYCLES=8 → req drops after 8 cycles; err pulses; odata=0; a later stray ack is ignored.
- Assert RST_X=0 mid-REQ, ack arrives the cycle after reset releases → busy=0, req=0, odata=0; state stays IDLE.
- With PTE_PORT_LASTHIT_EN: two reads of 0x8000_2000 → second causes no DRAM req and busy is 1 cycle; after w_tlb_flush, a third read goes to DRAM.

Source files
------------

// File: rtl/pte_mem_port.sv
// PTE read / write-back responder for the MMU page walker, sequenced onto the DRAM word port.
// Define PTE_PORT_LASTHIT_EN to add a one-entry last-hit buffer that answers repeat reads locally.
module pte_mem_port #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  CLK,
   input  logic                  RST_X,
   input  logic                  w_pte_req,
   input  logic                  w_pte_we,
   input  logic [ADDR_WIDTH-1:0] w_pte_addr,
   input  logic [31:0]           w_pte_wdata,
   input  logic                  w_tlb_flush,
   output logic                  w_pte_busy,
   output logic [31:0]           w_pte_odata,
   output logic                  w_pte_err,
   output logic                  w_dram_req,
   output logic                  w_dram_we,
   output logic [ADDR_WIDTH-1:0] w_dram_addr,
   output logic [31:0]           w_dram_wdata,
   input  logic                  w_dram_ack,
   input  logic [31:0]           w_dram_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

   state_t                state, state_nx;
   logic [15:0]           cnt, cnt_nx;
   logic                  busy_nx, err_nx, req_nx, we_nx;
   logic [31:0]           odata_nx, wdata_nx;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic                  timeout, hit;

`ifdef PTE_PORT_LASTHIT_EN
   logic                  ent_v, ent_v_nx;
   logic [ADDR_WIDTH-1:0] ent_addr, ent_addr_nx;
   logic [31:0]           ent_data, ent_data_nx;

   assign hit = !w_pte_we && ent_v && (ent_addr == w_pte_addr);
`else
   logic unused_flush;

   assign unused_flush = w_tlb_flush;
   assign hit          = 1'b0;
`endif

   // Abort when the cycle now ending would be the TIMEOUT_CYCLES-th without an ack.
   assign timeout = ({1'b0, cnt} + 17'd1) >= TIMEOUT_LIM;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      busy_nx  = w_pte_busy;
      odata_nx = w_pte_odata;
      err_nx   = 1'b0;
      req_nx   = w_dram_req;
      we_nx    = w_dram_we;
      addr_nx  = w_dram_addr;
      wdata_nx = w_dram_wdata;
`ifdef PTE_PORT_LASTHIT_EN
      ent_v_nx    = ent_v;
      ent_addr_nx = ent_addr;
      ent_data_nx = ent_data;
`endif
      case (state)
         IDLE: begin
            if (w_pte_req) begin
               if (w_pte_addr[1:0] != 2'b00) begin
                  err_nx = 1'b1;
               end else if (hit) begin
                  busy_nx  = 1'b1;
                  state_nx = DONE;
`ifdef PTE_PORT_LASTHIT_EN
                  odata_nx = ent_data;
`endif
               end else begin
                  busy_nx  = 1'b1;
                  req_nx   = 1'b1;
                  we_nx    = w_pte_we;
                  addr_nx  = w_pte_addr;
                  wdata_nx = w_pte_wdata;
                  cnt_nx   = 16'd0;
                  state_nx = REQ;
               end
            end
         end
         REQ: begin
            err_nx = w_pte_req;
            cnt_nx = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
            if (w_dram_ack) begin
               req_nx   = 1'b0;
               state_nx = DONE;
               if (!w_dram_we) odata_nx = w_dram_rdata;
`ifdef PTE_PORT_LASTHIT_EN
               ent_v_nx    = 1'b1;
               ent_addr_nx = w_dram_addr;
               ent_data_nx = w_dram_we ? w_dram_wdata : w_dram_rdata;
`endif
            end else if (timeout) begin
               req_nx   = 1'b0;
               err_nx   = 1'b1;
               state_nx = DONE;
               if (!w_dram_we) odata_nx = 32'd0;
`ifdef PTE_PORT_LASTHIT_EN
               ent_v_nx = 1'b0;
`endif
            end
         end
         DONE: begin
            err_nx   = w_pte_req;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
`ifdef PTE_PORT_LASTHIT_EN
      if (w_tlb_flush) ent_v_nx = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         w_pte_busy   <= 1'b0;
         w_pte_odata  <= 32'd0;
         w_pte_err    <= 1'b0;
         w_dram_req   <= 1'b0;
         w_dram_we    <= 1'b0;
         w_dram_addr  <= '0;
         w_dram_wdata <= 32'd0;
`ifdef PTE_PORT_LASTHIT_EN
         ent_v        <= 1'b0;
         ent_addr     <= '0;
         ent_data     <= 32'd0;
`endif
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         w_pte_busy   <= busy_nx;
         w_pte_odata  <= odata_nx;
         w_pte_err    <= err_nx;
         w_dram_req   <= req_nx;
         w_dram_we    <= we_nx;
         w_dram_addr  <= addr_nx;
         w_dram_wdata <= wdata_nx;
`ifdef PTE_PORT_LASTHIT_EN
         ent_v        <= ent_v_nx;
         ent_addr     <= ent_addr_nx;
         ent_data     <= ent_data_nx;
`endif
      end
   end

endmodule

// File: tb/tb_pte_mem_port.sv
// Self-checking bench for pte_mem_port: transaction-level model checked every cycle plus directed scenarios.
module tb_pte_mem_port;

   localparam int TO = 8;

   logic        CLK = 1'b0;
   logic        RST_X = 1'b0;
   logic        w_pte_req = 1'b0;
   logic        w_pte_we = 1'b0;
   logic [31:0] w_pte_addr = 32'd0;
   logic [31:0] w_pte_wdata = 32'd0;
   logic        w_tlb_flush = 1'b0;
   logic        w_pte_busy;
   logic [31:0] w_pte_odata;
   logic        w_pte_err;
   logic        w_dram_req;
   logic        w_dram_we;
   logic [31:0] w_dram_addr;
   logic [31:0] w_dram_wdata;
   logic        w_dram_ack = 1'b0;
   logic [31:0] w_dram_rdata = 32'd0;

   int checks = 0;
   int fails = 0;
   bit checkEn = 1'b0;

   pte_mem_port #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .w_pte_req(w_pte_req), .w_pte_we(w_pte_we), .w_pte_addr(w_pte_addr),
      .w_pte_wdata(w_pte_wdata), .w_tlb_flush(w_tlb_flush),
      .w_pte_busy(w_pte_busy), .w_pte_odata(w_pte_odata), .w_pte_err(w_pte_err),
      .w_dram_req(w_dram_req), .w_dram_we(w_dram_we), .w_dram_addr(w_dram_addr),
      .w_dram_wdata(w_dram_wdata), .w_dram_ack(w_dram_ack), .w_dram_rdata(w_dram_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model: an accepted request waits for ack or the timeout, then holds busy one more cycle.
   bit        inFlight = 0, finishing = 0;
   int        waited = 0;
   logic      e_busy = 0, e_req = 0, e_we = 0, e_err = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_odata = 0;
   bit        entValid = 0;
   logic [31:0] entAddr = 0, entData = 0;

   always @(posedge CLK) begin
      if (!RST_X) begin
         inFlight = 0; finishing = 0; waited = 0;
         e_busy = 0; e_req = 0; e_we = 0; e_err = 0;
         e_addr = 0; e_wdata = 0; e_odata = 0; entValid = 0;
      end else begin
         e_err = 0;
         if (finishing) begin
            finishing = 0;
            e_busy = 0;
            if (w_pte_req) e_err = 1;
         end else if (inFlight) begin
            if (w_pte_req) e_err = 1;
            waited++;
            if (w_dram_ack) begin
               inFlight = 0; finishing = 1; e_req = 0;
               if (!e_we) e_odata = w_dram_rdata;
               entValid = 1; entAddr = e_addr;
               entData = e_we ? e_wdata : w_dram_rdata;
            end else if (waited >= TO) begin
               inFlight = 0; finishing = 1; e_req = 0; e_err = 1; entValid = 0;
               if (!e_we) e_odata = 0;
            end
         end else if (w_pte_req) begin
            if (w_pte_addr % 4 != 0) begin
               e_err = 1;
`ifdef PTE_PORT_LASTHIT_EN
            end else if (!w_pte_we && entValid && entAddr == w_pte_addr) begin
               finishing = 1; e_busy = 1; e_odata = entData;
`endif
            end else begin
               inFlight = 1; waited = 0; e_busy = 1; e_req = 1;
               e_we = w_pte_we; e_addr = w_pte_addr; e_wdata = w_pte_wdata;
            end
         end
         if (w_tlb_flush) entValid = 0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (checkEn) begin
         checkOutput("busy", 32'(w_pte_busy), 32'(e_busy));
         checkOutput("dram_req", 32'(w_dram_req), 32'(e_req));
         checkOutput("err", 32'(w_pte_err), 32'(e_err));
         if (e_req) begin
            checkOutput("dram_we", 32'(w_dram_we), 32'(e_we));
            checkOutput("dram_addr", w_dram_addr, e_addr);
            checkOutput("dram_wdata", w_dram_wdata, e_wdata);
         end
         if (!e_busy) checkOutput("odata", w_pte_odata, e_odata);
      end
   end

   // Strobe one request, then act as DRAM for a fixed window, acking on the ackAt-th req-high cycle.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int ackAt, input logic [31:0] rdata, input int window,
                                output int reqCycles, output int busyCycles, output int errCycles,
                                output logic seenWe, output logic [31:0] seenAddr, output logic [31:0] seenWdata);
      reqCycles = 0; busyCycles = 0; errCycles = 0;
      seenWe = 0; seenAddr = 0; seenWdata = 0;
      @(negedge CLK);
      w_pte_req = 1; w_pte_we = we; w_pte_addr = addr; w_pte_wdata = wdata;
      @(negedge CLK);
      w_pte_req = 0;
      for (int i = 0; i < window; i++) begin
         w_dram_ack = 0;
         if (w_dram_req) begin
            reqCycles++;
            seenWe = w_dram_we; seenAddr = w_dram_addr; seenWdata = w_dram_wdata;
         end
         if (w_pte_busy) busyCycles++;
         if (w_pte_err) errCycles++;
         if (w_dram_req && reqCycles == ackAt) begin
            w_dram_ack = 1; w_dram_rdata = rdata;
         end
         @(negedge CLK);
      end
      w_dram_ack = 0;
   endtask

   int rq, bz, er;
   logic sWe;
   logic [31:0] sAddr, sWdata;

   initial begin
      repeat (2) @(negedge CLK);
      RST_X = 1;
      checkEn = 1;
      checkOutput("reset_busy", 32'(w_pte_busy), 32'd0);
      checkOutput("reset_req", 32'(w_dram_req), 32'd0);
      checkOutput("reset_odata", w_pte_odata, 32'd0);
      checkOutput("reset_err", 32'(w_pte_err), 32'd0);

      $display("[TB] read with 3-cycle DRAM latency");
      applyStimulus(0, 32'h8000_1004, 32'd0, 3, 32'h2000_00CF, 6, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("rd_req_cycles", 32'(rq), 32'd3);
      checkOutput("rd_busy_cycles", 32'(bz), 32'd4);
      checkOutput("rd_addr", sAddr, 32'h8000_1004);
      checkOutput("rd_we", 32'(sWe), 32'd0);
      checkOutput("rd_odata", w_pte_odata, 32'h2000_00CF);

      $display("[TB] zero-wait write-back");
      applyStimulus(1, 32'h8000_1004, 32'h2000_00CF, 1, 32'hFFFF_FFFF, 4, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("wr_req_cycles", 32'(rq), 32'd1);
      checkOutput("wr_busy_cycles", 32'(bz), 32'd2);
      checkOutput("wr_we", 32'(sWe), 32'd1);
      checkOutput("wr_wdata", sWdata, 32'h2000_00CF);
      checkOutput("wr_odata_kept", w_pte_odata, 32'h2000_00CF);

      $display("[TB] misaligned read");
      applyStimulus(0, 32'h8000_1006, 32'd0, 1, 32'd0, 3, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("mis_req_cycles", 32'(rq), 32'd0);
      checkOutput("mis_busy_cycles", 32'(bz), 32'd0);
      checkOutput("mis_err_cycles", 32'(er), 32'd1);

      $display("[TB] read timeout then stray ack");
      applyStimulus(0, 32'h8000_1010, 32'd0, 0, 32'd0, 12, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("to_req_cycles", 32'(rq), 32'(TO));
      checkOutput("to_busy_cycles", 32'(bz), 32'(TO + 1));
      checkOutput("to_err_cycles", 32'(er), 32'd1);
      checkOutput("to_odata", w_pte_odata, 32'd0);
      w_dram_ack = 1; w_dram_rdata = 32'h5555_AAAA;
      @(negedge CLK);
      w_dram_ack = 0;
      @(negedge CLK);
      checkOutput("stray_odata", w_pte_odata, 32'd0);
      checkOutput("stray_busy", 32'(w_pte_busy), 32'd0);

      $display("[TB] read to load odata");
      applyStimulus(0, 32'h8000_1008, 32'd0, 2, 32'h1234_5678, 5, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("rd2_odata", w_pte_odata, 32'h1234_5678);

      $display("[TB] request and flush while busy");
      er = 0;
      @(negedge CLK);
      w_pte_req = 1; w_pte_we = 0; w_pte_addr = 32'h8000_3000;
      @(negedge CLK);
      w_pte_we = 1; w_pte_addr = 32'h8000_4000; w_pte_wdata = 32'h0BAD_0BAD; w_tlb_flush = 1;
      @(negedge CLK);
      w_pte_req = 0; w_tlb_flush = 0;
      for (int i = 0; i < 5; i++) begin
         w_dram_ack = (i == 0);
         w_dram_rdata = 32'hCAFE_0001;
         if (w_pte_err) er++;
         @(negedge CLK);
      end
      w_dram_ack = 0;
      checkOutput("busy_req_err", 32'(er), 32'd1);
      checkOutput("busy_req_odata", w_pte_odata, 32'hCAFE_0001);

      $display("[TB] reset during REQ");
      @(negedge CLK);
      w_pte_req = 1; w_pte_we = 0; w_pte_addr = 32'h8000_1020;
      @(negedge CLK);
      w_pte_req = 0;
      @(negedge CLK);
      RST_X = 0;
      @(negedge CLK);
      RST_X = 1; w_dram_ack = 1; w_dram_rdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      w_dram_ack = 0;
      @(negedge CLK);
      checkOutput("rst_busy", 32'(w_pte_busy), 32'd0);
      checkOutput("rst_req", 32'(w_dram_req), 32'd0);
      checkOutput("rst_odata", w_pte_odata, 32'd0);

`ifdef PTE_PORT_LASTHIT_EN
      $display("[TB] last-hit buffer");
      applyStimulus(0, 32'h8000_2000, 32'd0, 2, 32'h0000_1111, 5, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("lh_first_req", 32'(rq), 32'd2);
      applyStimulus(0, 32'h8000_2000, 32'd0, 1, 32'hFFFF_0000, 4, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("lh_hit_req", 32'(rq), 32'd0);
      checkOutput("lh_hit_busy", 32'(bz), 32'd1);
      checkOutput("lh_hit_odata", w_pte_odata, 32'h0000_1111);
      w_tlb_flush = 1;
      @(negedge CLK);
      w_tlb_flush = 0;
      applyStimulus(0, 32'h8000_2000, 32'd0, 1, 32'h0000_2222, 4, rq, bz, er, sWe, sAddr, sWdata);
      checkOutput("lh_flush_req", 32'(rq), 32'd1);
      checkOutput("lh_flush_odata", w_pte_odata, 32'h0000_2222);
`endif

      repeat (2) @(negedge CLK);
      checkEn = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
